// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU port (r0) and a loader (r1).
// Define ARB_STATS_EN to add per-requester completed-transaction counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_cnt0,
  output logic [31:0]       stat_cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [3:0] LatCnt = 4'(MEM_LAT);

  state_e     state_q;
  logic       last_gnt_q;  // 1: r1 was granted most recently
  logic       owner_q;     // 1: r1 owns the in-flight transaction
  logic [3:0] cnt_q;
  logic       pick_r1;

  // On a tie, the requester not served last wins.
  assign pick_r1 = r1_req && (!r0_req || !last_gnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      r0_gnt     <= 1'b0;
      r0_done    <= 1'b0;
      r0_rdata   <= '0;
      r1_gnt     <= 1'b0;
      r1_done    <= 1'b0;
      r1_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ARB_STATS_EN
      stat_cnt0  <= '0;
      stat_cnt1  <= '0;
`endif
    end else begin
      mem_en  <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (r0_req || r1_req) begin
            owner_q    <= pick_r1;
            last_gnt_q <= pick_r1;
            r0_gnt     <= !pick_r1;
            r1_gnt     <= pick_r1;
            mem_en     <= 1'b1;
            mem_we     <= pick_r1 ? r1_we    : r0_we;
            mem_addr   <= pick_r1 ? r1_addr  : r0_addr;
            mem_wdata  <= pick_r1 ? r1_wdata : r0_wdata;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= LatCnt;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q <= StDone;
            if (owner_q) begin
              r1_done <= 1'b1;
              if (!mem_we) r1_rdata <= mem_rdata;
`ifdef ARB_STATS_EN
              stat_cnt1 <= stat_cnt1 + 32'd1;
`endif
            end else begin
              r0_done <= 1'b1;
              if (!mem_we) r0_rdata <= mem_rdata;
`ifdef ARB_STATS_EN
              stat_cnt0 <= stat_cnt0 + 32'd1;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          r0_gnt  <= 1'b0;
          r1_gnt  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a timing-arithmetic reference model and directed
// checks; a second instance with MEM_LAT=3 covers long latency and mid-transaction reset.
module tb_mem_port_arbiter;
  localparam int unsigned L = 1;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_done, r1_gnt, r1_done;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] stat_cnt0, stat_cnt1, a_stat0, a_stat1;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_l3 (
    .clk(clk), .rst(rst3),
    .r0_req(a_req), .r0_we(a_we), .r0_addr(a_addr), .r0_wdata(a_wdata),
    .r0_gnt(a_gnt), .r0_done(a_done), .r0_rdata(a_rdata),
    .r1_req(b_req), .r1_we(b_we), .r1_addr(b_addr), .r1_wdata(b_wdata),
    .r1_gnt(b_gnt), .r1_done(b_done), .r1_rdata(b_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_cnt0(a_stat0), .stat_cnt1(a_stat1)
`endif
  );

  // Bench memory: read data is valid only in the cycle exactly MEM_LAT after mem_en.
  logic [31:0] arr [16];
  bit          mem_init_done;
  logic [31:0] garbage;
  logic [7:0]  rd_cnt, rd3_cnt;
  logic [3:0]  rd_idx, rd3_idx;

  always @(posedge clk) begin
    garbage <= $urandom;
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) arr[i] <= 32'hA5A5_0000 + i;
      arr[4] <= 32'hDEAD_BEEF;
      mem_init_done <= 1'b1;
      rd_cnt  <= 8'd0;
      rd3_cnt <= 8'd0;
      rd_idx  <= 4'd0;
      rd3_idx <= 4'd0;
    end else begin
      if (mem_en && mem_we) arr[mem_addr[5:2]] <= mem_wdata;
      if (mem_en) begin
        rd_idx <= mem_addr[5:2];
        rd_cnt <= 8'd1;
      end else if (rd_cnt != 8'd0 && rd_cnt < 8'd15) rd_cnt <= rd_cnt + 8'd1;
      if (a_mem_en) begin
        rd3_idx <= a_mem_addr[5:2];
        rd3_cnt <= 8'd1;
      end else if (rd3_cnt != 8'd0 && rd3_cnt < 8'd15) rd3_cnt <= rd3_cnt + 8'd1;
    end
  end

  assign mem_rdata   = (rd_cnt == 8'(L)) ? arr[rd_idx] : garbage;
  assign a_mem_rdata = (rd3_cnt == 8'd3) ? arr[rd3_idx] : ~garbage;

  // Reference model: a transaction issued in cycle ti holds its grant through ti+L+1,
  // strobes the memory in ti only and completes in ti+L+1.
  bit          m_valid, m_busy, m_own, m_last;
  int unsigned m_ti;
  logic [31:0] m_rdata0, m_rdata1, e_mem_addr, e_mem_wdata;
  logic        e_mem_we;
  logic [31:0] m_stat0, m_stat1;
  logic        pick1;

  assign pick1 = (r0_req && r1_req) ? !m_last : r1_req;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_valid <= 1'b1;
      m_busy <= 1'b0;
      m_last <= 1'b1;
      m_rdata0 <= '0;
      m_rdata1 <= '0;
      e_mem_we <= 1'b0;
      e_mem_addr <= '0;
      e_mem_wdata <= '0;
      m_stat0 <= '0;
      m_stat1 <= '0;
    end else if (m_busy) begin
      if (cyc == m_ti + L) begin
        if (!e_mem_we) begin
          if (m_own) m_rdata1 <= arr[e_mem_addr[5:2]];
          else m_rdata0 <= arr[e_mem_addr[5:2]];
        end
        if (m_own) m_stat1 <= m_stat1 + 1;
        else m_stat0 <= m_stat0 + 1;
      end else if (cyc == m_ti + L + 1) begin
        m_busy <= 1'b0;
      end
    end else if (r0_req || r1_req) begin
      m_busy <= 1'b1;
      m_own <= pick1;
      m_last <= pick1;
      m_ti <= cyc + 1;
      e_mem_we <= pick1 ? r1_we : r0_we;
      e_mem_addr <= pick1 ? r1_addr : r0_addr;
      e_mem_wdata <= pick1 ? r1_wdata : r0_wdata;
    end
  end

  logic in_txn, e_gnt0, e_gnt1, e_done0, e_done1, e_en;
  assign in_txn  = m_busy && (cyc >= m_ti) && (cyc <= m_ti + L + 1);
  assign e_gnt0  = in_txn && !m_own;
  assign e_gnt1  = in_txn && m_own;
  assign e_done0 = m_busy && !m_own && (cyc == m_ti + L + 1);
  assign e_done1 = m_busy && m_own && (cyc == m_ti + L + 1);
  assign e_en    = m_busy && (cyc == m_ti);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("r0_gnt", 32'(r0_gnt), 32'(e_gnt0));
      chk("r1_gnt", 32'(r1_gnt), 32'(e_gnt1));
      chk("gnt_exclusive", 32'(r0_gnt & r1_gnt), 32'd0);
      chk("r0_done", 32'(r0_done), 32'(e_done0));
      chk("r1_done", 32'(r1_done), 32'(e_done1));
      chk("r0_rdata", r0_rdata, m_rdata0);
      chk("r1_rdata", r1_rdata, m_rdata1);
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_mem_we));
      chk("mem_addr", mem_addr, e_mem_addr);
      chk("mem_wdata", mem_wdata, e_mem_wdata);
`ifdef ARB_STATS_EN
      chk("stat_cnt0", stat_cnt0, m_stat0);
      chk("stat_cnt1", stat_cnt1, m_stat1);
`endif
    end
  end

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic do_txn(input bit who, input bit we, input logic [31:0] a, input logic [31:0] w);
    bit seen = 1'b0;
    @(negedge clk);
    if (who) begin r1_we = we; r1_addr = a; r1_wdata = w; r1_req = 1'b1; end
    else begin r0_we = we; r0_addr = a; r0_wdata = w; r0_req = 1'b1; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = who ? r1_done : r0_done;
    end
    if (who) r1_req = 1'b0;
    else r0_req = 1'b0;
    chk("txn_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic rand_fields(output logic we, output logic [31:0] a, output logic [31:0] w);
    we = 1'($urandom_range(1, 0));
    a  = {26'd0, 4'($urandom_range(15, 0)), 2'b00};
    w  = $urandom;
  endtask

  task automatic drive_rand();
    logic we;
    logic [31:0] a, w;
    rst = ($urandom_range(399, 0) == 0);
    if (!r0_req || r0_done) begin
      if ($urandom_range(2, 0) != 0) begin
        rand_fields(we, a, w);
        r0_we = we; r0_addr = a; r0_wdata = w; r0_req = 1'b1;
      end else r0_req = 1'b0;
    end else if ($urandom_range(63, 0) == 0) r0_req = 1'b0;
    if (!r1_req || r1_done) begin
      if ($urandom_range(2, 0) != 0) begin
        rand_fields(we, a, w);
        r1_we = we; r1_addr = a; r1_wdata = w; r1_req = 1'b1;
      end else r1_req = 1'b0;
    end else if ($urandom_range(63, 0) == 0) r1_req = 1'b0;
  endtask

  task automatic l3_read_check(input string tag);
    @(negedge clk);
    a_we = 1'b0; a_addr = 32'h10; a_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk({tag, "_mem_en"}, 32'(a_mem_en), 32'(k == 1));
      chk({tag, "_gnt"}, 32'(a_gnt), 32'(k <= 5));
      chk({tag, "_done"}, 32'(a_done), 32'(k == 5));
      if (k == 5) begin
        chk({tag, "_rdata"}, a_rdata, 32'hDEAD_BEEF);
        a_req = 1'b0;
      end
    end
  endtask

  initial begin
    int order [8];
    int n;
    rst = 1'b1; rst3 = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst3 = 1'b0;

    chk("rst_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    chk("rst_done", 32'({r0_done, r1_done}), 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    chk("rst_mem_ctl", 32'({mem_en, mem_we}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // r0 read of 0x10, default latency
    @(negedge clk);
    r0_we = 1'b0; r0_addr = 32'h10; r0_req = 1'b1;
    @(negedge clk);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_gnt", 32'({r0_gnt, r1_gnt}), 32'b10);
    @(negedge clk);
    chk("t1_wait_en", 32'(mem_en), 32'd0);
    chk("t1_wait_gnt", 32'(r0_gnt), 32'd1);
    @(negedge clk);
    chk("t1_done", 32'(r0_done), 32'd1);
    chk("t1_rdata", r0_rdata, 32'hDEAD_BEEF);
    chk("t1_done_gnt", 32'(r0_gnt), 32'd1);
    r0_req = 1'b0;
    @(negedge clk);
    chk("t1_after_gnt", 32'(r0_gnt), 32'd0);
    chk("t1_after_done", 32'(r0_done), 32'd0);

    // MEM_LAT=3: normal read, then reset two cycles into WAIT
    l3_read_check("l3a");
    @(negedge clk);
    a_we = 1'b0; a_addr = 32'h10; a_req = 1'b1;
    @(negedge clk);
    chk("l3b_mem_en", 32'(a_mem_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1; a_req = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    chk("l3b_rst_gnt", 32'(a_gnt), 32'd0);
    chk("l3b_rst_done", 32'(a_done), 32'd0);
    chk("l3b_rst_rdata", a_rdata, 32'd0);
    chk("l3b_rst_mem", 32'({a_mem_en, a_mem_we}), 32'd0);
    chk("l3b_rst_addr", a_mem_addr, 32'd0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_done || a_gnt) n++;
    end
    chk("l3b_no_done", 32'(n), 32'd0);
    l3_read_check("l3c");

    // Tie right after reset: r0 first, then r1 write
    pulse_rst();
    r0_we = 1'b0; r0_addr = 32'h20; r0_req = 1'b1;
    r1_we = 1'b1; r1_addr = 32'h4; r1_wdata = 32'h1234_5678; r1_req = 1'b1;
    @(negedge clk);
    chk("t2_first_gnt", 32'({r0_gnt, r1_gnt}), 32'b10);
    chk("t2_first_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_r0_done", 32'(r0_done), 32'd1);
    r0_req = 1'b0;
    @(negedge clk);
    chk("t2_idle_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    @(negedge clk);
    chk("t2_r1_en", 32'(mem_en), 32'd1);
    chk("t2_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("t2_r1_we", 32'(mem_we), 32'd1);
    chk("t2_r1_addr", mem_addr, 32'h4);
    chk("t2_r1_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    chk("t2_r1_done", 32'(r1_done), 32'd1);
    chk("t2_r1_rdata", r1_rdata, 32'd0);
    r1_req = 1'b0;
    @(negedge clk);
    chk("t2_mem_written", arr[1], 32'h1234_5678);

    // Both held high: strict alternation
    r0_we = 1'b0; r0_addr = 32'h8; r0_req = 1'b1;
    r1_we = 1'b0; r1_addr = 32'hC; r1_req = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      @(negedge clk);
      if (r0_done && n < 8) begin order[n] = 0; n++; end
      if (r1_done && n < 8) begin order[n] = 1; n++; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("alt_count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) chk("alt_order", 32'(order[i]), 32'(i % 2));

    // Transaction counting
    pulse_rst();
    do_txn(1'b0, 1'b0, 32'h0, 32'h0);
    do_txn(1'b0, 1'b0, 32'h14, 32'h0);
    do_txn(1'b1, 1'b1, 32'h18, 32'hCAFE_0001);
    do_txn(1'b0, 1'b0, 32'h18, 32'h0);
    do_txn(1'b1, 1'b1, 32'h1C, 32'hCAFE_0002);
    chk("cnt_r0_read", r0_rdata, 32'hCAFE_0001);
`ifdef ARB_STATS_EN
    @(negedge clk);
    chk("stat0_lit", stat_cnt0, 32'd3);
    chk("stat1_lit", stat_cnt1, 32'd2);
    pulse_rst();
    chk("stat0_rst", stat_cnt0, 32'd0);
    chk("stat1_rst", stat_cnt1, 32'd0);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      drive_rand();
    end
    @(negedge clk);
    rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
